tcnt_delay_sched: RTL
=====================

Name: tcnt_delay_sched

Overview:
- Shared hardware delay timer for the tcnt timing infrastructure; the synthesizable counterpart of the delay_ns/us/ms services.
- N requesters each post a delay (count + unit).
- A round-robin scheduler grants one requester at a time to a single prescaled countdown engine, then pulses that requester's done line.
- Also provides a free-running cycle timestamp for event stamping.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, 16, width of each requested delay count.
- CYC_PER_US, 1000, clock cycles per "us" unit tick (≥1).
- US_PER_MS, 1000, us ticks per "ms" unit tick (≥1).
- TSW, 48, timestamp width.

Ports:
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, N_REQ, per-requester request.
- req_delay, in, N_REQ*DW, delay count; slice i = [i*DW +: DW].
- req_unit, in, N_REQ*2, per-requester unit: 0=cycle, 1=us, 2=ms, 3=reserved (treated as 0).
- req_ready, out, N_REQ, one-hot grant; accept = valid&ready.
- done, out, N_REQ, one-cycle completion pulse to granted requester.
- flush, in, 1, abort current delay.
- busy, out, 1, high in RUN or DONE.
- grant_id, out, $clog2(N_REQ), index of current/last granted requester.
- timestamp, out, TSW, free-running cycle counter.

Behaviour:
- Reset: state=IDLE, req_ready=0, done=0, busy=0, grant_id=0, RR pointer=0, timestamp=0, all counters 0.
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- timestamp increments every non-reset cycle; wraps 2^TSW-1 -> 0; unaffected by flush.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational: one-hot on the first valid index scanning from RR pointer upward, with wrap.
  - req_ready is all-zero if flush=1 or no request is valid.
  - On accept at cycle t: latch delay D and unit multiplier M (1, CYC_PER_US, or CYC_PER_US*US_PER_MS); grant_id<=i; pointer<=(i+1) mod N_REQ; go to RUN.
- Latency: done[grant_id] is high exactly at cycle t+max(1, D*M).
  - D=0 completes at t+1.
  - Product D*M is never formed as a full-width multiply; realised as a prescaler (0..M-1) counting down with the unit counter.
- RUN -> DONE on the cycle the countdown expires; done pulses in the DONE cycle; DONE -> IDLE next cycle.
  - req_ready=0 during RUN and DONE; earliest next accept is t_done+1.
- busy=1 in RUN/DONE, 0 in IDLE; grant_id holds after completion.
- flush=1:
  - In RUN: go to IDLE next cycle; no done pulse; pointer keeps its post-grant value.
  - In DONE: done still pulses that cycle.
  - In IDLE: blocks accept.
- req_valid deassertion while the request is pending (not yet accepted) is legal; no state effect.
- Inputs of the granted requester are ignored after accept.
- rst mid-RUN: all state returns to reset values next edge; no done pulse.
- Requests with unit=3 behave exactly as unit=0.

Test Plan:
- Single request: req0 D=5 unit=0 accepted at t -> done[0] high only at t+5; busy high t+1..t+5; req_ready[0] again at t+6.
- Zero and unit delays: D=0 -> done at t+1. CYC_PER_US=4, unit=1, D=3 -> done at t+12. US_PER_MS=2, unit=2, D=1 -> done at t+8. Unit=3, D=2 -> done at t+2.
- Round robin: req0, req1, req2 held valid continuously with D=1 -> grants in order 0,1,2. Then drop req1 -> next grant is 0, then 2; grant_id matches each time.
- Flush mid-run: unit=0, D=100, flush at t+40 -> no done pulse; busy=0 from t+41; a pending req accepted at t+41 if flush is low.
- Reset mid-run: rst at t+10 of D=50 -> outputs at reset values next cycle; no done pulse; pointer=0; timestamp=0.
- Timestamp wrap: with TSW=4 -> sequence …14, 15, 0, 1; unaffected by flush and requests.

Source files
------------

// File: rtl/tcnt_delay_sched.sv
// Shared delay timer: round-robin grant of N requesters onto one prescaled countdown
// engine, a one-cycle done pulse per completed delay, and a free-running timestamp.
module tcnt_delay_sched #(
  parameter int N_REQ      = 4,
  parameter int DW         = 16,
  parameter int CYC_PER_US = 1000,
  parameter int US_PER_MS  = 1000,
  parameter int TSW        = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_delay,
  input  logic [N_REQ*2-1:0]       req_unit,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         done,
  input  logic                     flush,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [TSW-1:0]           timestamp
);
  localparam int GW    = $clog2(N_REQ);
  localparam int M_MAX = CYC_PER_US * US_PER_MS;
  localparam int PW    = (M_MAX > 1) ? $clog2(M_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [DW-1:0]  ucnt_reg;
  logic [PW-1:0]  pre_reg;
  logic [PW-1:0]  pre_top_reg;
  logic [GW-1:0]  ptr_reg;
  logic [GW-1:0]  grant_id_reg;
  logic [TSW-1:0] ts_reg;

  logic [GW-1:0]  cand [N_REQ];
  logic           sel_found;
  logic [GW-1:0]  sel_idx;
  logic [DW-1:0]  sel_delay;
  logic [1:0]     sel_unit;
  int             sel_mult;
  logic           accept;
  logic           quick;
  logic           expire;
  logic [DW-1:0]  load_ucnt;
  logic [PW-1:0]  load_pre;
  logic [PW-1:0]  load_top;

  function automatic int unit_mult(input logic [1:0] unit);
    case (unit)
      2'd1:    return CYC_PER_US;
      2'd2:    return M_MAX;
      default: return 1;
    endcase
  endfunction

  // cand[k] is the requester index k places above the round-robin pointer.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign cand[gi] = GW'((int'(ptr_reg) + gi) % N_REQ);
      assign done[gi] = (state_reg == S_DONE) && (grant_id_reg == GW'(gi));
    end
  endgenerate

  // Total RUN cycles must be D*M-1; the remaining count is ucnt*M + pre, and the
  // last RUN cycle is the one where both reach zero, so D*M-2 is preloaded.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[k];
      end
    end
    sel_delay = req_delay[sel_idx*DW +: DW];
    sel_unit  = req_unit[sel_idx*2 +: 2];
    sel_mult  = unit_mult(sel_unit);
    accept    = (state_reg == S_IDLE) && !flush && sel_found;
    quick     = (sel_delay == '0) || ((sel_delay == DW'(1)) && (sel_mult == 1));
    load_top  = PW'(sel_mult - 1);
    if (sel_mult >= 2) begin
      load_ucnt = sel_delay - DW'(1);
      load_pre  = PW'(sel_mult - 2);
    end else begin
      load_ucnt = sel_delay - DW'(2);
      load_pre  = '0;
    end
    expire = (ucnt_reg == '0) && (pre_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ucnt_reg     <= '0;
      pre_reg      <= '0;
      pre_top_reg  <= '0;
      ptr_reg      <= '0;
      grant_id_reg <= '0;
      ts_reg       <= '0;
    end else begin
      state_reg <= state_next;
      ts_reg    <= ts_reg + TSW'(1);
      if (accept) begin
        grant_id_reg <= sel_idx;
        ptr_reg      <= (sel_idx == GW'(N_REQ - 1)) ? '0 : sel_idx + GW'(1);
        ucnt_reg     <= load_ucnt;
        pre_reg      <= load_pre;
        pre_top_reg  <= load_top;
      end else if (state_reg == S_RUN) begin
        if (pre_reg == '0) begin
          pre_reg  <= pre_top_reg;
          ucnt_reg <= ucnt_reg - DW'(1);
        end else begin
          pre_reg <= pre_reg - PW'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = quick ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)       state_next = S_IDLE;
        else if (expire) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[sel_idx] = 1'b1;
    busy = (state_reg != S_IDLE);
  end

  assign grant_id  = grant_id_reg;
  assign timestamp = ts_reg;

endmodule
